// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg: FSM state encodings and seven-segment constants (gfedcba, active-high).
package count_monitor_pkg;
    typedef enum logic [1:0] {UNLOCKED = 2'd0, LOCKED = 2'd1, FAULT = 2'd2} state_t;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    function automatic logic [2:0] succ(input logic [2:0] v);
        return v + 3'd1;
    endfunction
endpackage

// File: rtl/count_monitor_if.sv
// count_monitor_if: sequencer input, clear request and monitor status outputs.
interface count_monitor_if #(parameter int LAP_W = 8, parameter int ERR_W = 4);
    logic [2:0] cnt_in;
    logic clr_err;
    logic [6:0] seg;
    logic locked;
    logic err;
    logic [ERR_W-1:0] err_cnt;
    logic [LAP_W-1:0] lap_cnt;
    modport master (output cnt_in, clr_err, input seg, locked, err, err_cnt, lap_cnt);
    modport slave (input cnt_in, clr_err, output seg, locked, err, err_cnt, lap_cnt);
endinterface

// File: rtl/count_monitor_seg7_dec.sv
// seg7_dec: combinational 3-bit to seven-segment decode.
module seg7_dec
    import count_monitor_pkg::*;
(
    input  logic [2:0] val,
    output logic [6:0] seg
);
    always_comb begin
        case (val)
            3'd0: seg = SEG_0;
            3'd1: seg = SEG_1;
            3'd2: seg = SEG_2;
            3'd3: seg = SEG_3;
            3'd4: seg = SEG_4;
            3'd5: seg = SEG_5;
            3'd6: seg = SEG_6;
            default: seg = SEG_7;
        endcase
    end
endmodule

// File: rtl/count_monitor.sv
// count_monitor: checks a mod-8 count stream for +1 steps, tracking lock, errors and laps.
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int LAP_W = 8,
    parameter int ERR_W = 4
) (
    input logic clk,
    input logic reset,
    count_monitor_if.slave bus
);
    state_t state, nxt;
    logic [2:0] prev;
    logic [6:0] seg_d, seg_q;
    logic locked, err;
    logic [ERR_W-1:0] err_cnt;
    logic [LAP_W-1:0] lap_cnt;
    logic expected, fault_evt, lap_evt;

    seg7_dec u_dec (.val(bus.cnt_in), .seg(seg_d));

    assign expected  = bus.cnt_in == succ(prev);
    assign fault_evt = state == LOCKED && !expected;
    // expected with prev == 7 already implies cnt_in == 0
    assign lap_evt   = state == LOCKED && expected && prev == 3'd7;

    always_comb nxt = (state == UNLOCKED || expected) ? LOCKED : FAULT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= UNLOCKED;
            prev    <= '0;
            seg_q   <= SEG_BLANK;
            locked  <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
            lap_cnt <= '0;
        end else begin
            state  <= nxt;
            locked <= nxt == LOCKED;
            prev   <= bus.cnt_in;
            seg_q  <= seg_d;
            if (lap_evt && lap_cnt != '1)
                lap_cnt <= lap_cnt + 1'b1;
            // a new fault outranks a simultaneous clear
            if (fault_evt) begin
                err     <= 1'b1;
                err_cnt <= bus.clr_err ? ERR_W'(1) : (err_cnt == '1 ? err_cnt : err_cnt + 1'b1);
            end else if (bus.clr_err) begin
                err     <= 1'b0;
                err_cnt <= '0;
            end
        end
    end

    assign bus.seg     = seg_q;
    assign bus.locked  = locked;
    assign bus.err     = err;
    assign bus.err_cnt = err_cnt;
    assign bus.lap_cnt = lap_cnt;
endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter LAP_W, default 8, width of the completed-lap counter.
REQ-002 Parameter ERR_W, default 4, width of the error-event counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 cnt_in  input  3  count value from the upstream 3-bit mod-8 sequencer, one new value per clk.
REQ-006 clr_err  input  1  synchronous request to clear err and err_cnt.
REQ-007 seg  output  7  registered seven-segment code of cnt_in, bit order gfedcba, active-high.
REQ-008 locked  output  1  high while the FSM is in LOCKED.
REQ-009 err  output  1  sticky sequence-error flag.
REQ-010 err_cnt  output  ERR_W  count of LOCKED->FAULT events, saturating.
REQ-011 lap_cnt  output  LAP_W  count of observed 7->0 wraps while LOCKED, saturating.

Function
REQ-012 FSM states SHALL be UNLOCKED, LOCKED and FAULT; locked = (state == LOCKED), registered.
REQ-013 Register prev SHALL hold the previous cycle's cnt_in; in every non-reset cycle prev <= cnt_in.
REQ-014 "expected" SHALL mean cnt_in == (prev + 1) mod 8, i.e. 3-bit wrap-around addition, so 7 -> 0 is legal.
REQ-015 UNLOCKED: capture cnt_in into prev, then go to LOCKED unconditionally on the next edge; no checking in this cycle.
REQ-016 LOCKED, expected: stay LOCKED; if prev == 7 and cnt_in == 0, increment lap_cnt, saturating at 2^LAP_W-1.
REQ-017 LOCKED, not expected: go to FAULT, set err, increment err_cnt, saturating at 2^ERR_W-1; lap_cnt unchanged.
REQ-018 FAULT, expected: return to LOCKED; no lap increment on this resync edge, even for 7 -> 0.
REQ-019 FAULT, not expected: stay in FAULT; err_cnt unchanged.
REQ-020 clr_err SHALL clear err and err_cnt on the next edge; it SHALL NOT affect the state, lap_cnt or prev.
REQ-021 Simultaneous clr_err and a LOCKED mismatch: the mismatch wins, giving err = 1 and err_cnt = 1 after the edge.
REQ-022 seg SHALL be a one-cycle-latency decode of cnt_in.
REQ-023 seg decode table: 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66, 5 = 0x6D, 6 = 0x7D, 7 = 0x07.

Reset
REQ-024 On reset: state = UNLOCKED, prev = 0, seg = 0x00 (blank), locked = 0, err = 0, err_cnt = 0, lap_cnt = 0.
REQ-025 Reset SHALL take priority over clr_err and all FSM activity, including reset asserted mid-lap or in FAULT.
REQ-026 The first cnt_in sampled after reset deassertion SHALL be accepted without error, via UNLOCKED.

Structure
REQ-027 A shared package/include SHALL hold the state encodings (UNLOCKED = 0, LOCKED = 1, FAULT = 2) and the eight segment constants.
REQ-028 The segment decode SHALL be one combinational sub-module, seg7_dec (3-bit in, 7-bit out), reused by later display blocks.
REQ-029 The top SHALL contain only the FSM, the prev/seg registers and the two saturating counters.

Verification
REQ-030 Release reset, then drive 0,1,...,7,0,1 -> locked = 1 from the 2nd edge, lap_cnt = 1 after the 7 -> 0 edge, err = 0.
REQ-031 Drive 3,4,6,7 -> FAULT after the 6 edge, err = 1, err_cnt = 1, then LOCKED after the 7 edge; lap_cnt unchanged.
REQ-032 Drive 17 successive mismatch/resync pairs with ERR_W = 4 -> err_cnt holds at 15.
REQ-033 Assert clr_err in the same cycle as a mismatch -> err = 1, err_cnt = 1; assert clr_err alone -> err = 0, err_cnt = 0 next cycle.
REQ-034 Assert reset mid-sequence with lap_cnt = 5 -> all outputs at reset values next edge; first post-reset value is accepted with no error.
REQ-035 Sweep cnt_in over 0..7 -> seg matches the REQ-023 table exactly one cycle later.
